// File: rtl/seq_adder.sv
//------------------------------------------------------------------------------
// Module   : seq_adder
// Brief    : Multi-cycle adder/subtractor, SLICE bits per clock through a
//            ripple chain of full-adder cells, start/busy/done handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic [SLICE:0]   w_c;
    logic [SLICE-1:0] w_s;
    logic [WIDTH-1:0] w_res_next;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_cnt == C_LAST);
    assign busy     = w_run;
    assign done     = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == C_LAST) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Ripple chain over the current low slice of the operand shift registers
    assign w_c[0] = r_carry;
    for (genvar i = 0; i < SLICE; i++) begin : g_cell
        assign w_s[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
        assign w_c[i+1] = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
    end

    // Result slices enter from the top so the first slice ends at bit 0
    if (NSLICE == 1) begin : g_res_single
        assign w_res_next = w_s;
    end else begin : g_res_multi
        assign w_res_next = {w_s, r_res[WIDTH-1:SLICE]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= r_a >> SLICE;
            r_b     <= r_b >> SLICE;
            r_res   <= w_res_next;
            r_carry <= w_c[SLICE];
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                sum  <= w_res_next;
                cout <= w_c[SLICE];
                ovf  <= w_c[SLICE] ^ w_c[SLICE-1];
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/seq_adder.md
# seq_adder

Parametrised multi-cycle adder/subtractor, the sequential successor to the team's single-bit full adder. It adds or subtracts two WIDTH-bit operands SLICE bits per clock through an internal ripple chain of SLICE full-adder cells, carrying between slices in a register. Operands and results move over a start/busy/done handshake, so the block can sit behind a controller or datapath sequencer where a full-width combinational adder is too large or too slow.

## Interface
- WIDTH, 16, operand/result width in bits; must be ≥1.
- SLICE, 4, bits processed per cycle; WIDTH % SLICE == 0 required; NSLICE = WIDTH/SLICE.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- sub  in  1  0: a+b+cin; 1: a-b-cin; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- cin  in  1  carry-in (add) / borrow-in (sub); captured with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse, result valid.
- sum  out  WIDTH  result, registered, held until next completion.
- cout  out  1  raw carry out of MSB (in sub: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Reset state IDLE.
- IDLE/DONE + start=1: capture a into shift register A; capture b (sub=0) or ~b (sub=1) into shift register B; carry register ← cin (sub=0) or ~cin (sub=1); slice counter ← 0; → RUN.
- DONE + start=0 → IDLE. IDLE + start=0 → IDLE.
- RUN, each cycle: add low SLICE bits of A and B plus carry register through the SLICE-cell ripple chain; shift result slice into result shift register from the top; shift A and B right by SLICE; carry register ← chain carry-out; counter++.
- RUN on last slice (counter == NSLICE-1): sum ← assembled result; cout ← chain carry-out; ovf ← carry into MSB XOR carry out of MSB; → DONE.
- start while in RUN is ignored; operands are not re-captured.
- sub=1 computes a + ~b + ~cin, i.e. a − b − cin modulo 2^WIDTH.
- WIDTH bits exactly; no sign extension, no saturation.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0; state IDLE; internal shift registers, carry, counter = 0.
- rst dominates start and all state; asserting rst during RUN aborts the operation: next edge gives IDLE, busy=0, done=0, sum/cout/ovf=0, no done pulse ever issued for the aborted op.
- Start accepted at edge E0 → busy=1 from E0 through E0+NSLICE-1 edges; at edge E0+NSLICE: busy=0, done=1, sum/cout/ovf updated.
- Latency: NSLICE cycles from accepting edge to done; done high exactly one cycle.
- Back-to-back: start held high during the DONE cycle is accepted; throughput one result per NSLICE+1 cycles.
- NSLICE=1 (SLICE=WIDTH): one RUN cycle, then DONE.
- sum/cout/ovf change only on the completion edge or reset; stable at all other times, including during RUN of the next op.
- busy and done never high in the same cycle.

## Test plan
- WIDTH=16,SLICE=4: a=0x0001,b=0xFFFF,cin=0,sub=0 → done 4 cycles after accepting edge, sum=0x0000,cout=1,ovf=0; busy high exactly 4 cycles.
- a=0x7FFF,b=0x0001,sub=0 → sum=0x8000,cout=0,ovf=1; then a=0x0005,b=0x0007,cin=0,sub=1 → sum=0xFFFE,cout=0,ovf=0.
- Pulse start again at RUN cycle 2 with different operands → ignored, result matches first op; then hold start high through DONE → second op accepted, second done exactly 5 cycles after first.
- Assert rst for one cycle at RUN cycle 2 → next cycle busy=0,done=0,sum=0,cout=0,ovf=0; no done pulse in the following 10 cycles.
- WIDTH=3,SLICE=1: all 2×8×8×2 combinations of sub,a,b,cin → {cout,sum} equals a+b+cin (sub=0) or a+~b+~cin (sub=1) mod 16; ovf matches signed reference.
- WIDTH=8,SLICE=8: a=0x80,b=0x80,cin=1 → done 1 cycle after accept, sum=0x01,cout=1,ovf=1.
